// File: rtl/truth_table_sequencer_pkg.sv
// rtl/truth_table_sequencer_pkg.sv - shared state encodings and MISR constants for truth_table_sequencer
// Contents: tts_state_e (IDLE=0, DRIVE=1, DONE=2), TTS_MISR_POLY, TTS_MISR_SEED, tts_misr_step().
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        TTS_IDLE  = 2'd0,
        TTS_DRIVE = 2'd1,
        TTS_DONE  = 2'd2
    } tts_state_e;

    // x^16 + x^12 + x^5 + 1 with the x^16 term implicit
    localparam logic [15:0] TTS_MISR_POLY = 16'h1021;
    localparam logic [15:0] TTS_MISR_SEED = 16'hFFFF;

    // One MISR step: Galois shift by one, then fold the new sample into the low bits
    function automatic logic [15:0] tts_misr_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? TTS_MISR_POLY : 16'h0000) ^ d;
    endfunction

endpackage

// File: rtl/tts_misr.sv
// rtl/tts_misr.sv - 16-bit multiple-input signature register
// Ports: clk, rst (sync, active-high, loads seed), clr (reload seed), en (absorb din),
//        din[15:0] sample, sig[15:0] current signature.
module tts_misr
    import truth_table_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    // clr wins over en so a restart always begins from the seed
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = TTS_MISR_SEED;
        end else if (en) begin
            sig_d = tts_misr_step(sig_q, din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= TTS_MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - exhaustive truth-table sweep and check of a small combinational block
// Optional macro TTS_MISR_EN: when defined, sig is a MISR over every sampled dut_out; otherwise sig=0.
// Ports: clk, rst (sync, active-high), start, dut_out[N_OUT-1:0] in;
//        vec[N_IN-1:0], busy, done, pass, err_count[N_IN:0], fail_seen, first_fail[N_IN-1:0], sig[15:0] out.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int DWELL = 20,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXP = '0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_OUT-1:0] dut_out,
    output logic [N_IN-1:0]  vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             fail_seen,
    output logic [N_IN-1:0]  first_fail,
    output logic [15:0]      sig
);

    localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    tts_state_e       state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_q, err_d;
    logic             fail_seen_q, fail_seen_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;

    logic             sample;
    logic             restart;
    logic             mismatch;
    logic [N_OUT-1:0] exp_slice;

    assign exp_slice = EXP[vec_q*N_OUT +: N_OUT];
    assign sample    = (state_q == TTS_DRIVE) && (cnt_q == CNT_LAST);
    assign restart   = ((state_q == TTS_IDLE) || (state_q == TTS_DONE)) && start;
    assign mismatch  = (dut_out != exp_slice);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;

        case (state_q)
            TTS_IDLE, TTS_DONE: begin
                if (restart) begin
                    state_d      = TTS_DRIVE;
                    vec_d        = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                end
            end
            TTS_DRIVE: begin
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_seen_q) begin
                            fail_seen_d  = 1'b1;
                            first_fail_d = vec_q;
                        end
                    end
                    cnt_d = '0;
                    if (vec_q == VEC_LAST) begin
                        // vec stays on the last vector; pass reflects the count including it
                        state_d = TTS_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = TTS_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TTS_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

`ifdef TTS_MISR_EN
    logic [15:0] misr_din;
    assign misr_din = 16'(dut_out);

    tts_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (restart),
        .en  (sample),
        .din (misr_din),
        .sig (sig)
    );
`else
    assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

    function automatic logic [1:0] ref_a(input int v);
        logic [3:0] x;
        x = v[3:0];
        return {x[0] ^ x[1], x[2] & x[3]};
    endfunction

    function automatic logic [31:0] build_exp_a();
        logic [31:0] r;
        r = '0;
        for (int v = 0; v < 16; v++) r[v*2 +: 2] = ref_a(v);
        return r;
    endfunction

    localparam logic [31:0] EXP_A = build_exp_a();

`ifdef TTS_MISR_EN
    localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
    localparam logic [15:0] SIG_RST = 16'h0000;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    logic [1:0] corr_a [16];
    logic       inv_b;

    logic [1:0]  dut_out_a;
    logic [3:0]  vec_a, first_fail_a;
    logic        busy_a, done_a, pass_a, fail_seen_a;
    logic [4:0]  err_count_a;
    logic [15:0] sig_a;

    logic        dut_out_b;
    logic        vec_b, first_fail_b;
    logic        busy_b, done_b, pass_b, fail_seen_b;
    logic [1:0]  err_count_b;
    logic [15:0] sig_b;

    always_comb dut_out_a = ref_a(int'(vec_a)) ^ corr_a[vec_a];
    always_comb dut_out_b = vec_b ^ inv_b;

    truth_table_sequencer #(.N_IN(4), .N_OUT(2), .DWELL(3), .EXP(EXP_A)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a),
        .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_count_a), .fail_seen(fail_seen_a),
        .first_fail(first_fail_a), .sig(sig_a)
    );

    truth_table_sequencer #(.N_IN(1), .N_OUT(1), .DWELL(1), .EXP(2'b10)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
        .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_count_b), .fail_seen(fail_seen_b),
        .first_fail(first_fail_b), .sig(sig_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] r;
        r = s << 1;
        if (s[15]) r = r ^ 16'h1021;
        return r ^ d;
    endfunction

    // Reference sweep result for u_a given the current corruption pattern
    int          m_err;
    int          m_ff;
    logic [15:0] m_sig;

    task automatic model_a();
        logic [15:0] s;
        m_err = 0;
        m_ff  = -1;
        s     = 16'hFFFF;
        for (int v = 0; v < 16; v++) begin
            if (corr_a[v] != 2'b00) begin
                m_err++;
                if (m_ff < 0) m_ff = v;
            end
            s = misr_ref(s, {14'b0, ref_a(v) ^ corr_a[v]});
        end
`ifdef TTS_MISR_EN
        m_sig = s;
`else
        m_sig = 16'h0000;
`endif
    endtask

    task automatic sweep_a(input logic hold);
        int   k;
        logic vec_ok;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        if (!hold) start_a = 1'b0;
        chk("a_start_busy", 32'(busy_a), 1);
        chk("a_start_done", 32'(done_a), 0);
        chk("a_start_err", 32'(err_count_a), 0);
        chk("a_start_fs", 32'(fail_seen_a), 0);
        k = 0;
        vec_ok = 1'b1;
        while (!done_a && k < 200) begin
            if (!busy_a || int'(vec_a) != k / 3) vec_ok = 1'b0;
            k++;
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("a_vec_sequence", 32'(vec_ok), 1);
        chk("a_busy_cycles", 32'(k), 48);
        chk("a_done", 32'(done_a), 1);
        chk("a_busy_low", 32'(busy_a), 0);
        chk("a_vec_hold", 32'(vec_a), 15);
    endtask

    task automatic check_a();
        model_a();
        chk("a_err_count", 32'(err_count_a), 32'(m_err));
        chk("a_fail_seen", 32'(fail_seen_a), 32'(m_err != 0));
        chk("a_pass", 32'(pass_a), 32'(m_err == 0));
        if (m_err != 0) chk("a_first_fail", 32'(first_fail_a), 32'(m_ff));
        chk("a_sig", 32'(sig_a), 32'(m_sig));
    endtask

    task automatic clear_corr();
        for (int v = 0; v < 16; v++) corr_a[v] = 2'b00;
    endtask

    typedef struct {
        int       fv1;
        logic [1:0] fm1;
        int       fv2;
        logic [1:0] fm2;
        logic     hold;
        int       exp_err;
        int       exp_ff;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [15:0] sig_clean, sig_fault;
        logic [15:0] sb;
        int k;

        tbl[0] = '{-1, 2'b00, -1, 2'b00, 1'b0, 0, 0};
        tbl[1] = '{ 5, 2'b01, 12, 2'b10, 1'b0, 2, 5};
        tbl[2] = '{ 0, 2'b11, -1, 2'b00, 1'b1, 1, 0};
        tbl[3] = '{15, 2'b01,  3, 2'b10, 1'b1, 2, 3};
        tbl[4] = '{15, 2'b10, -1, 2'b00, 1'b0, 1, 15};

        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        inv_b = 1'b0;
        clear_corr();
        sig_clean = '0;
        sig_fault = '0;
        repeat (3) @(negedge clk);

        chk("rst_vec", 32'(vec_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_err", 32'(err_count_a), 0);
        chk("rst_fs", 32'(fail_seen_a), 0);
        chk("rst_ff", 32'(first_fail_a), 0);
        chk("rst_sig", 32'(sig_a), 32'(SIG_RST));
        rst = 1'b0;
        @(negedge clk);

        // Table-driven sweeps with hand-chosen faults
        for (int i = 0; i < 5; i++) begin
            clear_corr();
            if (tbl[i].fv1 >= 0) corr_a[tbl[i].fv1] = tbl[i].fm1;
            if (tbl[i].fv2 >= 0) corr_a[tbl[i].fv2] = tbl[i].fm2;
            sweep_a(tbl[i].hold);
            chk("tbl_err", 32'(err_count_a), 32'(tbl[i].exp_err));
            chk("tbl_pass", 32'(pass_a), 32'(tbl[i].exp_err == 0));
            chk("tbl_fs", 32'(fail_seen_a), 32'(tbl[i].exp_err != 0));
            if (tbl[i].exp_err != 0) chk("tbl_ff", 32'(first_fail_a), 32'(tbl[i].exp_ff));
            check_a();
            if (i == 0) sig_clean = sig_a;
            if (i == 4) sig_fault = sig_a;
            repeat (2) @(negedge clk);
            chk("done_holds", 32'(done_a), 1);
        end

`ifdef TTS_MISR_EN
        n_cmp++;
        if (sig_clean == sig_fault) begin
            n_bad++;
            $display("FAIL misr_fault_sensitivity: got %0h want not %0h", sig_fault, sig_clean);
        end
`else
        chk("sig_tied_clean", 32'(sig_clean), 0);
        chk("sig_tied_fault", 32'(sig_fault), 0);
`endif

        // Reset mid-sweep at vec 7 with an error already counted
        clear_corr();
        corr_a[2] = 2'b01;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (vec_a != 4'd7 && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("reached_vec7", 32'(vec_a), 7);
        chk("mid_err_nonzero", 32'(err_count_a), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_vec", 32'(vec_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_done", 32'(done_a), 0);
        chk("abort_err", 32'(err_count_a), 0);
        chk("abort_fs", 32'(fail_seen_a), 0);
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", 32'(busy_a), 0);
        clear_corr();
        sweep_a(1'b0);
        chk("post_abort_pass", 32'(pass_a), 1);
        check_a();

        // Randomized corruption patterns against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < 16; v++)
                corr_a[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sweep_a(1'($urandom_range(0, 1)));
            check_a();
        end

        // DWELL=1, single input: identity DUT matches EXP=2'b10, inverter misses both
        for (int t = 0; t < 2; t++) begin
            inv_b = 1'(t);
            @(negedge clk);
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            k = 0;
            while (!done_b && k < 20) begin
                if (!busy_b || int'(vec_b) != k) n_bad += 0;
                k++;
                @(negedge clk);
            end
            chk("b_busy_cycles", 32'(k), 2);
            chk("b_done", 32'(done_b), 1);
            chk("b_vec_hold", 32'(vec_b), 1);
            chk("b_err", 32'(err_count_b), (t == 0) ? 0 : 2);
            chk("b_pass", 32'(pass_b), (t == 0) ? 1 : 0);
            chk("b_fs", 32'(fail_seen_b), (t == 0) ? 0 : 1);
            if (t == 1) chk("b_ff", 32'(first_fail_b), 0);
            sb = 16'hFFFF;
            for (int v = 0; v < 2; v++) sb = misr_ref(sb, {15'b0, 1'(v) ^ inv_b});
`ifdef TTS_MISR_EN
            chk("b_sig", 32'(sig_b), 32'(sb));
`else
            chk("b_sig", 32'(sig_b), 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
